// File: rtl/pstruct_cfg_pkg.sv
// pstruct_cfg_pkg: shared types and constants for the packed-struct config arbiter
package pstruct_cfg_pkg;

    typedef struct packed {
        logic [7:0] ctrl;
        logic [8:0] data;
    } cfg_t;

    localparam logic FIELD_DATA = 1'b0;
    localparam logic FIELD_CTRL = 1'b1;
    localparam int   DATA_MSB   = 8;
    localparam int   CTRL_MSB   = 7;

    typedef enum logic {IDLE, APPLY} arb_state_e;

endpackage

// File: rtl/pstruct_field_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set bit at or after ptr with wrap
module rr_pick #(
    parameter int N = 3,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx
);

    // scan downward so the candidate closest to ptr is assigned last and wins
    always_comb begin
        logic [W-1:0] c;
        c = '0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            c = W'((int'(ptr) + k) % N);
            if (req[c]) idx = c;
        end
        grant = '0;
        grant[idx] = |req;
    end

endmodule

// File: rtl/pstruct_field_arbiter.sv
// pstruct_field_arbiter: round-robin nibble writer into a locked packed-struct register
module pstruct_field_arbiter
    import pstruct_cfg_pkg::*;
#(
    parameter int         NREQ     = 3,
    parameter logic [8:0] RST_DATA = 9'h001
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_field,
    input  logic [NREQ*4-1:0] req_lsb,
    input  logic [NREQ*4-1:0] req_val,
    output logic [16:0]       cfg_q,
    output logic [7:0]        o,
    output logic              busy,
    output logic              err
);

    localparam int W = $clog2(NREQ);

    arb_state_e     state, state_next;
    cfg_t           cfg, upd;
    logic [W-1:0]   rr_ptr, widx;
    logic [NREQ-1:0] grant;
    logic           lat_field;
    logic [3:0]     lat_lsb, lat_val;
    logic [3:0]     lsb_a [NREQ];
    logic [3:0]     val_a [NREQ];
    logic           locked, oob;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign lsb_a[g] = req_lsb[g*4 +: 4];
        assign val_a[g] = req_val[g*4 +: 4];
    end

    rr_pick #(.N(NREQ), .W(W)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (widx)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // FSM next state: one accept cycle, one apply cycle
    always_comb begin
        state_next = (state == APPLY) ? IDLE : ((|req_valid) ? APPLY : IDLE);
    end

    // FSM outputs: grants only while idle, err flags dropped writes during apply
    always_comb begin
        locked    = cfg.ctrl[7] && (lat_field == FIELD_DATA);
        oob       = int'(lat_lsb) > ((lat_field == FIELD_CTRL) ? CTRL_MSB : DATA_MSB);
        req_ready = (state == IDLE) ? grant : '0;
        busy      = (state == APPLY);
        err       = (state == APPLY) && (locked || oob);
    end

    // read-modify-write of the latched member; shifts clip bits above the member msb
    always_comb begin
        upd = cfg;
        if (lat_field == FIELD_CTRL)
            upd.ctrl = (cfg.ctrl & ~(8'h0F << lat_lsb)) | (8'(lat_val) << lat_lsb);
        else if (!cfg.ctrl[7])
            upd.data = (cfg.data & ~(9'h00F << lat_lsb)) | (9'(lat_val) << lat_lsb);
    end

    // request latch, pointer advance and register commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg       <= '{ctrl: 8'h00, data: RST_DATA};
            rr_ptr    <= '0;
            lat_field <= FIELD_DATA;
            lat_lsb   <= '0;
            lat_val   <= '0;
        end else if (state == APPLY) begin
            cfg <= upd;
        end else if (|req_valid) begin
            lat_field <= req_field[widx];
            lat_lsb   <= lsb_a[widx];
            lat_val   <= val_a[widx];
            rr_ptr    <= (widx == W'(NREQ - 1)) ? '0 : widx + W'(1);
        end
    end

    assign cfg_q = cfg;
    assign o     = cfg.data[8:1];

endmodule

// File: tb/tb_pstruct_field_arbiter.sv
// tb_pstruct_field_arbiter: directed and randomized checks against a behavioural model
module tb_pstruct_field_arbiter;

    localparam int N = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_valid, req_ready, req_field;
    logic [N*4-1:0]   req_lsb, req_val;
    logic [16:0]      cfg_q;
    logic [7:0]       o;
    logic             busy, err;

    always #5 clk = ~clk;

    pstruct_field_arbiter #(.NREQ(N), .RST_DATA(9'h001)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_field (req_field),
        .req_lsb   (req_lsb),
        .req_val   (req_val),
        .cfg_q     (cfg_q),
        .o         (o),
        .busy      (busy),
        .err       (err)
    );

    int vectors = 0;
    int miscompares = 0;

    logic       rv [N];
    logic       rf [N];
    logic [3:0] rl [N];
    logic [3:0] rval [N];
    int         mode;

    logic [8:0] m_data;
    logic [7:0] m_ctrl;
    int         m_ptr;
    bit         m_pend;
    logic       m_f;
    logic [3:0] m_l, m_v;

    logic [N-1:0] obs_ready;
    logic         obs_busy, obs_err;
    logic         apply_err, apply_busy;
    logic [N-1:0] seq [7];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++)
            if (rv[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_data = 9'h001;
        m_ctrl = 8'h00;
        m_ptr  = 0;
        m_pend = 0;
    endtask

    task automatic model_apply();
        int msb;
        msb = m_f ? 7 : 8;
        if (m_f || !m_ctrl[7])
            for (int i = 0; i < 4; i++)
                if (int'(m_l) + i <= msb) begin
                    if (m_f) m_ctrl[int'(m_l) + i] = m_v[i];
                    else     m_data[int'(m_l) + i] = m_v[i];
                end
    endtask

    task automatic new_req(input int i);
        rv[i]   = 1'($urandom_range(1));
        rf[i]   = 1'($urandom_range(1));
        rl[i]   = ($urandom_range(7) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(9));
        rval[i] = 4'($urandom);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = rv[i];
            req_field[i]       = rf[i];
            req_lsb[i*4 +: 4]  = rl[i];
            req_val[i*4 +: 4]  = rval[i];
        end
    endtask

    task automatic tick();
        logic [N-1:0] er;
        logic ee;
        int w;
        drive();
        @(negedge clk);
        w  = m_pend ? -1 : pick();
        er = '0;
        if (w >= 0) er[w] = 1'b1;
        ee = m_pend && ((!m_f && m_ctrl[7]) || (int'(m_l) > (m_f ? 7 : 8)));
        obs_ready = req_ready;
        obs_busy  = busy;
        obs_err   = err;
        chk("ready", 32'(req_ready), 32'(er));
        chk("busy", 32'(busy), 32'(m_pend));
        chk("err", 32'(err), 32'(ee));
        chk("cfg_q", 32'(cfg_q), 32'({m_ctrl, m_data}));
        chk("o", 32'(o), 32'(m_data[8:1]));
        @(posedge clk);
        if (m_pend) begin
            model_apply();
            m_pend = 0;
        end else if (w >= 0) begin
            m_pend = 1;
            m_f    = rf[w];
            m_l    = rl[w];
            m_v    = rval[w];
            m_ptr  = (w + 1) % N;
        end
        #1;
        if (w >= 0) begin
            if (mode == 0) rv[w] = 1'b0;
            else if (mode == 2) new_req(w);
        end
        if (mode == 2)
            for (int i = 0; i < N; i++)
                if (!rv[i] && $urandom_range(3) == 0) new_req(i);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            rv[i] = 0; rf[i] = 0; rl[i] = 0; rval[i] = 0;
        end
        drive();
        model_reset();
        @(negedge clk);
        chk("rst_cfg", 32'(cfg_q), 32'h00001);
        chk("rst_o", 32'(o), 32'h00);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic write1(input logic f, input logic [3:0] l, input logic [3:0] v);
        rv[0] = 1'b1; rf[0] = f; rl[0] = l; rval[0] = v;
        tick();
        chk("w_ready", 32'(obs_ready), 32'h1);
        tick();
        apply_err  = obs_err;
        apply_busy = obs_busy;
    endtask

    initial begin
        mode = 0;
        do_reset();

        write1(1'b0, 4'd1, 4'hF);
        chk("single_busy", 32'(apply_busy), 32'h1);
        chk("single_data", 32'(cfg_q[8:0]), 32'h01F);
        chk("single_o", 32'(o), 32'h0F);

        do_reset();
        write1(1'b0, 4'd7, 4'hF);
        chk("clip_data", 32'(cfg_q[8:0]), 32'h181);
        chk("clip_err", 32'(apply_err), 32'h0);
        write1(1'b0, 4'd9, 4'hF);
        chk("oob_data", 32'(cfg_q[8:0]), 32'h181);
        chk("oob_err", 32'(apply_err), 32'h1);
        tick();
        chk("oob_err_once", 32'(obs_err), 32'h0);

        do_reset();
        mode = 1;
        for (int i = 0; i < N; i++) begin
            rv[i] = 1'b1; rf[i] = 1'b0; rl[i] = 4'(i); rval[i] = 4'(i + 1);
        end
        for (int c = 0; c < 7; c++) begin
            tick();
            seq[c] = obs_ready;
        end
        chk("rr0", 32'(seq[0]), 32'h1);
        chk("rr_gap", 32'(seq[1]), 32'h0);
        chk("rr1", 32'(seq[2]), 32'h2);
        chk("rr2", 32'(seq[4]), 32'h4);
        chk("rr3", 32'(seq[6]), 32'h1);
        mode = 0;
        for (int i = 0; i < N; i++) rv[i] = 1'b0;
        tick();

        do_reset();
        write1(1'b1, 4'd4, 4'h8);
        chk("lock_ctrl", 32'(cfg_q[16:9]), 32'h80);
        write1(1'b0, 4'd0, 4'hA);
        chk("lock_err", 32'(apply_err), 32'h1);
        chk("lock_data", 32'(cfg_q[8:0]), 32'h001);
        write1(1'b1, 4'd4, 4'h0);
        chk("unlock_ctrl", 32'(cfg_q[16:9]), 32'h00);
        chk("unlock_err", 32'(apply_err), 32'h0);
        write1(1'b0, 4'd0, 4'hA);
        chk("unlock_data", 32'(cfg_q[8:0]), 32'h00A);

        do_reset();
        rv[0] = 1'b1; rf[0] = 1'b0; rl[0] = 4'd0; rval[0] = 4'hA;
        tick();
        chk("mid_ready", 32'(obs_ready), 32'h1);
        #2 rst_n = 1'b0;
        rv[0] = 1'b0;
        drive();
        model_reset();
        @(negedge clk);
        chk("mid_err", 32'(err), 32'h0);
        chk("mid_busy", 32'(busy), 32'h0);
        chk("mid_cfg", 32'(cfg_q), 32'h00001);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("mid_after", 32'(cfg_q), 32'h00001);
        chk("mid_after_err", 32'(obs_err), 32'h0);

        do_reset();
        mode = 2;
        for (int i = 0; i < N; i++) new_req(i);
        for (int c = 0; c < 3000; c++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
